ili9341_pixel_streamer: RTL and testbench

// - Downstream consumer of the framebuffer BRAM read port (port b, 1-cycle registered read latency).
// - On start, sends ILI9341 Memory Write command 0x2C over the 8080 8-bit parallel bus.
// - Then streams NUM_PIXELS RGB565 words from addr 0 upward, high byte first, and pulses done.

---
 rtl/ili9341_pkg.sv | 21 ++
 rtl/ili9341_byte_writer.sv | 46 ++++
 rtl/ili9341_pixel_streamer.sv | 138 +++++++++++++
 tb/tb_ili9341_pixel_streamer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 framebuffer-to-panel streamer.
// Holds the panel command code, the streamer state encoding and the byte-cycle length helper.
package ili9341_pkg;

  localparam logic [7:0] CMD_MEMORY_WRITE = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_FETCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HI    = 3'd4,
    ST_LO    = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  function automatic int byte_cycle_len(input int low_cycles, input int high_cycles);
    return low_cycles + high_cycles;
  endfunction

endpackage

// File: rtl/ili9341_byte_writer.sv
// 8080-bus byte strobe generator: while req is held, drives wr_n low then high and
// pulses ack in the last high-phase cycle so the caller can advance on the same edge.
module ili9341_byte_writer
  import ili9341_pkg::*;
#(
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] wr_byte,
  input  logic       dc,
  output logic       wr_n,
  output logic [7:0] d,
  output logic       dc_out,
  output logic       ack
);

  localparam int BYTE_LEN = byte_cycle_len(WR_LOW_CYCLES, WR_HIGH_CYCLES);
  localparam int CNT_W    = $clog2(BYTE_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTE_LEN - 1);
  localparam logic [CNT_W-1:0] LOW_END  = CNT_W'(WR_LOW_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = '0;
    ack   = 1'b0;
    if (req) begin
      if (cnt_q == LAST_CNT) ack = 1'b1;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  // Bus is parked at d=0, dc=1, wr_n=1 whenever no byte is in flight.
  assign wr_n   = ~(req && (cnt_q < LOW_END));
  assign d      = req ? wr_byte : 8'h00;
  assign dc_out = req ? dc : 1'b1;

endmodule

// File: rtl/ili9341_pixel_streamer.sv
// Streams one frame from framebuffer BRAM port b to an ILI9341 over the 8080 8-bit bus:
// Memory Write command, then NUM_PIXELS RGB565 words high byte first, then a done pulse.
module ili9341_pixel_streamer
  import ili9341_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 16,
  parameter int NUM_PIXELS     = 1024,
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fb_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [DATA_W-1:0] fb_data,
  output logic              lcd_cs_n,
  output logic              lcd_dc,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
  output logic [7:0]        lcd_d
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic              req, ack, dc_sel;
  logic [7:0]        wr_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Pixel holding register is pure data and carries no reset.
  always_ff @(posedge clk) begin
    pix_q <= pix_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pix_d   = pix_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_CMD;
        idx_d   = '0;
      end
      ST_CMD:   if (ack) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        pix_d   = fb_data;
        state_d = ST_HI;
      end
      ST_HI:    if (ack) state_d = ST_LO;
      ST_LO: if (ack) begin
        if (idx_q == LAST_IDX) state_d = ST_FIN;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req      = 1'b0;
    wr_byte  = 8'h00;
    dc_sel   = 1'b1;
    fb_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    lcd_cs_n = 1'b1;
    unique case (state_q)
      ST_CMD: begin
        req      = 1'b1;
        wr_byte  = CMD_MEMORY_WRITE;
        dc_sel   = 1'b0;
        busy     = 1'b1;
        lcd_cs_n = 1'b0;
      end
      ST_FETCH: begin
        fb_en    = 1'b1;
        busy     = 1'b1;
        lcd_cs_n = 1'b0;
      end
      ST_WAIT: begin
        busy     = 1'b1;
        lcd_cs_n = 1'b0;
      end
      ST_HI: begin
        req      = 1'b1;
        wr_byte  = pix_q[DATA_W-1 -: 8];
        busy     = 1'b1;
        lcd_cs_n = 1'b0;
      end
      ST_LO: begin
        req      = 1'b1;
        wr_byte  = pix_q[7:0];
        busy     = 1'b1;
        lcd_cs_n = 1'b0;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  ili9341_byte_writer #(
    .WR_LOW_CYCLES (WR_LOW_CYCLES),
    .WR_HIGH_CYCLES(WR_HIGH_CYCLES)
  ) u_byte_writer (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .wr_byte(wr_byte),
    .dc     (dc_sel),
    .wr_n   (lcd_wr_n),
    .d      (lcd_d),
    .dc_out (lcd_dc),
    .ack    (ack)
  );

  assign fb_addr  = idx_q;
  assign lcd_rd_n = 1'b1;

endmodule

// File: tb/tb_ili9341_pixel_streamer.sv
// Bench for the ILI9341 streamer: a 4-pixel instance and a 1-pixel instance, each fed by a
// 1-cycle-latency BRAM model, with a bus monitor popping expected {dc,byte} from a queue.
module tb_ili9341_pixel_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start1;
  logic       busy, done, fb_en, cs_n, dc, wr_n, rd_n;
  logic [9:0] fb_addr;
  logic [15:0] fb_data = 16'h0000;
  logic [7:0] d;
  logic       busy1, done1, fb_en1, cs_n1, dc1, wr_n1, rd_n1;
  logic [9:0] fb_addr1;
  logic [15:0] fb_data1 = 16'h0000;
  logic [7:0] d1;

  ili9341_pixel_streamer #(.ADDR_W(10), .DATA_W(16), .NUM_PIXELS(4),
                           .WR_LOW_CYCLES(2), .WR_HIGH_CYCLES(2)) dut (
    .clk(clk), .reset(rst), .start(start), .busy(busy), .done(done),
    .fb_en(fb_en), .fb_addr(fb_addr), .fb_data(fb_data),
    .lcd_cs_n(cs_n), .lcd_dc(dc), .lcd_wr_n(wr_n), .lcd_rd_n(rd_n), .lcd_d(d));

  ili9341_pixel_streamer #(.ADDR_W(10), .DATA_W(16), .NUM_PIXELS(1),
                           .WR_LOW_CYCLES(2), .WR_HIGH_CYCLES(2)) dut1 (
    .clk(clk), .reset(rst), .start(start1), .busy(busy1), .done(done1),
    .fb_en(fb_en1), .fb_addr(fb_addr1), .fb_data(fb_data1),
    .lcd_cs_n(cs_n1), .lcd_dc(dc1), .lcd_wr_n(wr_n1), .lcd_rd_n(rd_n1), .lcd_d(d1));

  // BRAM port-b models: registered read, 1 cycle after enable.
  always @(posedge clk) if (fb_en)  fb_data  <= 16'hA500 + {6'd0, fb_addr};
  always @(posedge clk) if (fb_en1) fb_data1 <= 16'hF81F;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] exp_q[$];
  logic [8:0] exp_q1[$];
  int bytes_seen = 0, extra_bytes = 0, extra_bytes1 = 0;
  int low_cnt = 0, low_cnt1 = 0;
  int exp_addr = 0, fb1_cnt = 0;
  logic [9:0] fb1_addr = 10'h3FF;
  logic prev_wr_n = 1'b1, prev_dc = 1'b1, prev_wr_n1 = 1'b1, prev_dc1 = 1'b1;
  logic [7:0] prev_d = 8'h00, prev_d1 = 8'h00;

  // Bus monitors: a byte counts on a wr_n rising edge while the panel is selected.
  always @(negedge clk) begin
    if (!wr_n) low_cnt++;
    else begin
      if (!prev_wr_n && !cs_n) begin
        bytes_seen++;
        if (exp_q.size() == 0) extra_bytes++;
        else begin
          check("lcd_byte", {prev_dc, prev_d}, exp_q.pop_front());
          check("wr_low_len", low_cnt, 2);
        end
      end
      low_cnt = 0;
    end
    prev_wr_n = wr_n; prev_dc = dc; prev_d = d;
    if (fb_en) begin
      check("fb_addr", fb_addr, exp_addr);
      exp_addr++;
    end
  end

  always @(negedge clk) begin
    if (!wr_n1) low_cnt1++;
    else begin
      if (!prev_wr_n1 && !cs_n1) begin
        if (exp_q1.size() == 0) extra_bytes1++;
        else begin
          check("lcd_byte_n1", {prev_dc1, prev_d1}, exp_q1.pop_front());
          check("wr_low_len_n1", low_cnt1, 2);
        end
      end
      low_cnt1 = 0;
    end
    prev_wr_n1 = wr_n1; prev_dc1 = dc1; prev_d1 = d1;
    if (fb_en1) begin
      fb1_cnt++;
      fb1_addr = fb_addr1;
    end
  end

  task automatic push_frame4();
    exp_q.push_back({1'b0, 8'h2C});
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b1, 8'hA5});
      exp_q.push_back({1'b1, 8'(i)});
    end
  endtask

  // Pulses start and counts cycles with the start cycle as 1; optionally re-pulses start mid-frame.
  task automatic run_frame(input int busy_cyc, output int cyc);
    start = 1'b1;
    cyc = 1;
    for (int k = 0; k < 300; k++) begin
      tick();
      start = 1'b0;
      cyc++;
      if (cyc == 2) check("busy_after_start", busy, 1);
      if (cyc == busy_cyc) start = 1'b1;
      if (done) break;
    end
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    check("cs_n_at_done", cs_n, 1);
  endtask

  int cyc, extra_done, base;

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fb_en", fb_en, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_dc", dc, 1);
    check("rst_wr_n", wr_n, 1);
    check("rst_rd_n", rd_n, 1);
    check("rst_d", d, 0);
    rst = 1'b0;
    tick();

    // Plain 4-pixel frame
    exp_addr = 0;
    push_frame4();
    run_frame(0, cyc);
    check("frame_cycles", cyc, 46);
    tick();
    check("done_one_cycle", done, 0);
    check("queue_drained", exp_q.size(), 0);

    // Start while busy at cycle 10 must be ignored
    exp_addr = 0;
    base = bytes_seen;
    push_frame4();
    run_frame(10, cyc);
    check("busy_frame_cycles", cyc, 46);
    extra_done = 0;
    repeat (60) begin
      tick();
      if (done) extra_done++;
    end
    check("no_second_done", extra_done, 0);
    check("busy_frame_bytes", bytes_seen - base, 9);
    check("busy_frame_idle", busy, 0);

    // Single-pixel instance
    exp_q1.push_back({1'b0, 8'h2C});
    exp_q1.push_back({1'b1, 8'hF8});
    exp_q1.push_back({1'b1, 8'h1F});
    start1 = 1'b1;
    cyc = 1;
    for (int k = 0; k < 100; k++) begin
      tick();
      start1 = 1'b0;
      cyc++;
      if (done1) break;
    end
    check("n1_done_seen", done1, 1);
    check("n1_cycles", cyc, 16);
    tick();
    check("n1_fetch_count", fb1_cnt, 1);
    check("n1_fetch_addr", fb1_addr, 0);
    check("n1_queue_drained", exp_q1.size(), 0);

    // Reset during the low-byte write of pixel 2
    exp_addr = 0;
    base = bytes_seen;
    push_frame4();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if ((bytes_seen - base) >= 6 && !wr_n) break;
    end
    check("reached_px2_lo", bytes_seen - base, 6);
    check("px2_lo_wr_low", wr_n, 0);
    rst = 1'b1;
    tick();
    check("midrst_cs_n", cs_n, 1);
    check("midrst_wr_n", wr_n, 1);
    check("midrst_busy", busy, 0);
    check("midrst_d", d, 0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    tick();
    check("midrst_no_partial", bytes_seen - base, 6);

    // Restart after reset must begin again from the command and address 0
    exp_addr = 0;
    push_frame4();
    run_frame(0, cyc);
    check("restart_cycles", cyc, 46);
    tick();
    check("restart_queue_drained", exp_q.size(), 0);
    check("extra_bytes", extra_bytes, 0);
    check("extra_bytes_n1", extra_bytes1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
